// File: rtl/serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_rx
// Brief    : Oversampled asynchronous serial receiver with configurable width,
//            parity mode and stop-bit (framing) checking.
// Revision : 1.0 - initial release
// ============================================================================
module serial_rx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_MODE  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  serial_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int c_half  = CLKS_PER_BIT / 2;
    localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam bit c_par_en = (PARITY_MODE == 1) || (PARITY_MODE == 2);
    localparam bit c_odd    = (PARITY_MODE == 2);

    localparam logic [c_cnt_w-1:0] c_half_cnt = c_cnt_w'(c_half);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);
    localparam logic [4:0]         c_last_bit = 5'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [c_cnt_w-1:0]      cnt_q, cnt_d;
    logic [4:0]              bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    perr_pend_q, perr_pend_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    valid_q, valid_d;
    logic                    parity_err_q, parity_err_d;
    logic                    frame_err_q, frame_err_d;

    logic                    w_tick;
    logic                    w_par_exp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            perr_pend_q  <= 1'b0;
            data_out_q   <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            perr_pend_q  <= perr_pend_d;
            data_out_q   <= data_out_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Every sample after the start check lands on the last count of a bit period.
    assign w_tick    = (cnt_q == c_last_cnt);
    assign w_par_exp = (^shift_q) ^ c_odd;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        perr_pend_d  = perr_pend_q;
        data_out_d   = data_out_q;
        valid_d      = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (!serial_in) begin
                    bit_d = '0;
                    if (CLKS_PER_BIT == 1) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_START;
                        cnt_d   = c_one;
                    end
                end
            end
            S_START: begin
                if (cnt_q == c_half_cnt) begin
                    cnt_d   = '0;
                    state_d = serial_in ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + c_one;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    cnt_d   = '0;
                    shift_d = DATA_WIDTH'({serial_in, shift_q} >> 1);
                    if (bit_q == c_last_bit) begin
                        bit_d   = '0;
                        state_d = c_par_en ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end else begin
                    cnt_d = cnt_q + c_one;
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    cnt_d       = '0;
                    perr_pend_d = serial_in ^ w_par_exp;
                    state_d     = S_STOP;
                end else begin
                    cnt_d = cnt_q + c_one;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    // Results register here so they appear together with valid.
                    cnt_d        = '0;
                    valid_d      = 1'b1;
                    data_out_d   = shift_q;
                    parity_err_d = c_par_en & perr_pend_q;
                    frame_err_d  = ~serial_in;
                    state_d      = serial_in ? S_IDLE : S_WAIT_HIGH;
                end else begin
                    cnt_d = cnt_q + c_one;
                end
            end
            S_WAIT_HIGH: begin
                if (serial_in) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign data_out   = data_out_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_rx
// Brief    : Self-checking bench for serial_rx using per-cycle line waveforms
//            and a frame-level expectation model across four configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_rx;

    localparam int ND = 4;
    localparam int NC = 400;
    localparam int W_CFG  [ND] = '{8, 8, 8, 5};
    localparam int C_CFG  [ND] = '{4, 4, 4, 3};
    localparam int PM_CFG [ND] = '{1, 2, 0, 3};

    typedef struct packed {
        logic [1:0]  dut;
        logic [15:0] cyc;
        logic [15:0] data;
        logic        pe;
        logic        fe;
    } ev_t;

    logic          clk;
    logic          rst;
    logic [ND-1:0] ser;
    wire  [ND-1:0] vld, pe, fe, bsy;
    wire  [7:0]    dout0, dout1, dout2;
    wire  [4:0]    dout3;

    logic        wave     [ND][NC];
    logic        rst_wave [NC];
    logic        vlog     [ND][NC];
    logic [15:0] dlog     [ND][NC];
    logic        pelog    [ND][NC];
    logic        felog    [ND][NC];
    logic        blog     [ND][NC];
    ev_t         exp_q [$];
    ev_t         obs   [$];

    int checks = 0;
    int errors = 0;

    serial_rx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(1)) u_even (
        .clk(clk), .rst(rst), .serial_in(ser[0]), .data_out(dout0),
        .valid(vld[0]), .parity_err(pe[0]), .frame_err(fe[0]), .busy(bsy[0]));
    serial_rx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(2)) u_odd (
        .clk(clk), .rst(rst), .serial_in(ser[1]), .data_out(dout1),
        .valid(vld[1]), .parity_err(pe[1]), .frame_err(fe[1]), .busy(bsy[1]));
    serial_rx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(0)) u_none (
        .clk(clk), .rst(rst), .serial_in(ser[2]), .data_out(dout2),
        .valid(vld[2]), .parity_err(pe[2]), .frame_err(fe[2]), .busy(bsy[2]));
    serial_rx #(.DATA_WIDTH(5), .CLKS_PER_BIT(3), .PARITY_MODE(3)) u_alt (
        .clk(clk), .rst(rst), .serial_in(ser[3]), .data_out(dout3),
        .valid(vld[3]), .parity_err(pe[3]), .frame_err(fe[3]), .busy(bsy[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void clear_stim();
        for (int n = 0; n < NC; n++) begin
            rst_wave[n] = 1'b0;
            for (int d = 0; d < ND; d++) wave[d][n] = 1'b1;
        end
        exp_q.delete();
    endfunction

    // Paints one frame onto a line and, if asked, records the strobe it must produce.
    function automatic int add_frame(input int d, input int start, input logic [15:0] data,
                                     input logic pbit, input logic stopb, input bit expect_it);
        int          w    = W_CFG[d];
        int          c    = C_CFG[d];
        int          pm   = PM_CFG[d];
        bit          pen  = (pm == 1) || (pm == 2);
        logic [15:0] dm   = data & 16'((32'd1 << w) - 1);
        int          nb   = w + 2 + (pen ? 1 : 0);
        logic        good = (^dm) ^ (pm == 2);
        logic [31:0] bits = '0;
        for (int i = 0; i < w; i++) bits[1 + i] = dm[i];
        if (pen) bits[w + 1] = pbit;
        bits[nb - 1] = stopb;
        for (int b = 0; b < nb; b++)
            for (int j = 0; j < c; j++)
                if (start + b * c + j < NC) wave[d][start + b * c + j] = bits[b];
        if (expect_it)
            exp_q.push_back('{dut: 2'(d), cyc: 16'(start + c / 2 + (nb - 1) * c + 1),
                              data: dm, pe: pen && (pbit != good), fe: !stopb});
        return start + nb * c;
    endfunction

    task automatic run(input int ncyc);
        for (int n = 0; n < ncyc; n++) begin
            @(posedge clk);
            #1;
            rst = rst_wave[n];
            for (int d = 0; d < ND; d++) ser[d] = wave[d][n];
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                vlog[d][n]  = vld[d];
                pelog[d][n] = pe[d];
                felog[d][n] = fe[d];
                blog[d][n]  = bsy[d];
            end
            dlog[0][n] = {8'h00, dout0};
            dlog[1][n] = {8'h00, dout1};
            dlog[2][n] = {8'h00, dout2};
            dlog[3][n] = {11'h000, dout3};
        end
    endtask

    function automatic void collect(input int ncyc);
        obs.delete();
        for (int n = 0; n < ncyc; n++)
            for (int d = 0; d < ND; d++)
                if (vlog[d][n] === 1'b1)
                    obs.push_back('{dut: 2'(d), cyc: 16'(n), data: dlog[d][n],
                                    pe: pelog[d][n], fe: felog[d][n]});
    endfunction

    task automatic test_reset();
        clear_stim();
        for (int n = 0; n < 3; n++) rst_wave[n] = 1'b1;
        run(6);
        for (int d = 0; d < ND; d++) begin
            checks++;
            if ({vlog[d][4], dlog[d][4], pelog[d][4], felog[d][4], blog[d][4]} !== 20'h0) begin
                errors++;
                $display("FAIL reset dut%0d: got v=%b d=%h pe=%b fe=%b busy=%b, expected all 0",
                         d, vlog[d][4], dlog[d][4], pelog[d][4], felog[d][4], blog[d][4]);
            end
        end
    endtask

    task automatic test_nominal();
        int  e;
        bit  hit;
        clear_stim();
        e = add_frame(0, 0,  16'hA5, 1'b0, 1'b1, 1);
        e = add_frame(0, 60, 16'hA5, 1'b1, 1'b1, 1);
        e = add_frame(1, 0,  16'hA5, 1'b1, 1'b1, 1);
        e = add_frame(1, 60, 16'hA5, 1'b0, 1'b1, 1);
        e = add_frame(3, 0,  16'h13, 1'b1, 1'b1, 1);
        run(120);
        collect(120);
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL nominal strobe count: got %0d, expected %0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            hit = 0;
            foreach (obs[j]) if (obs[j] == exp_q[i]) hit = 1;
            checks++;
            if (!hit) begin
                errors++;
                $display("FAIL nominal strobe dut%0d@%0d: got v=%b d=%h pe=%b fe=%b, expected v=1 d=%h pe=%b fe=%b",
                         exp_q[i].dut, exp_q[i].cyc, vlog[exp_q[i].dut][exp_q[i].cyc],
                         dlog[exp_q[i].dut][exp_q[i].cyc], pelog[exp_q[i].dut][exp_q[i].cyc],
                         felog[exp_q[i].dut][exp_q[i].cyc], exp_q[i].data, exp_q[i].pe, exp_q[i].fe);
            end
        end
        checks++;
        if ({blog[0][0], blog[0][1], blog[0][42], blog[0][43]} !== 4'b0110) begin
            errors++;
            $display("FAIL nominal busy: got %b%b%b%b at cycles 0,1,42,43, expected 0110",
                     blog[0][0], blog[0][1], blog[0][42], blog[0][43]);
        end
        checks++;
        if (dlog[0][59] !== 16'h00A5 || pelog[0][59] !== 1'b0) begin
            errors++;
            $display("FAIL nominal hold: got d=%h pe=%b, expected d=00a5 pe=0", dlog[0][59], pelog[0][59]);
        end
    endtask

    task automatic test_framing();
        int  e;
        bit  hit;
        clear_stim();
        e = add_frame(0, 0, 16'h3C, 1'b0, 1'b0, 1);
        for (int t = e; t < e + 20; t++) wave[0][t] = 1'b0;
        e = add_frame(2, 0, 16'h3C, 1'b0, 1'b0, 1);
        for (int t = e; t < e + 20; t++) wave[2][t] = 1'b0;
        run(100);
        collect(100);
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL framing strobe count: got %0d, expected %0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            hit = 0;
            foreach (obs[j]) if (obs[j] == exp_q[i]) hit = 1;
            checks++;
            if (!hit) begin
                errors++;
                $display("FAIL framing strobe dut%0d@%0d: got v=%b d=%h pe=%b fe=%b, expected v=1 d=%h pe=%b fe=%b",
                         exp_q[i].dut, exp_q[i].cyc, vlog[exp_q[i].dut][exp_q[i].cyc],
                         dlog[exp_q[i].dut][exp_q[i].cyc], pelog[exp_q[i].dut][exp_q[i].cyc],
                         felog[exp_q[i].dut][exp_q[i].cyc], exp_q[i].data, exp_q[i].pe, exp_q[i].fe);
            end
        end
        checks++;
        if ({blog[0][50], blog[0][64], blog[0][65]} !== 3'b110) begin
            errors++;
            $display("FAIL framing busy: got %b%b%b at cycles 50,64,65, expected 110",
                     blog[0][50], blog[0][64], blog[0][65]);
        end
        checks++;
        if (felog[0][99] !== 1'b1) begin
            errors++;
            $display("FAIL framing flag hold: got fe=%b, expected 1", felog[0][99]);
        end
    endtask

    task automatic test_false_start();
        int  e;
        bit  hit;
        clear_stim();
        e = add_frame(0, 0, 16'h5A, 1'b1, 1'b1, 1);
        e = add_frame(1, 0, 16'h5A, 1'b0, 1'b1, 1);
        wave[0][60] = 1'b0;
        wave[1][60] = 1'b0;
        wave[1][61] = 1'b0;
        run(90);
        collect(90);
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL false_start strobe count: got %0d, expected %0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            hit = 0;
            foreach (obs[j]) if (obs[j] == exp_q[i]) hit = 1;
            checks++;
            if (!hit) begin
                errors++;
                $display("FAIL false_start strobe dut%0d@%0d: got v=%b d=%h pe=%b fe=%b, expected v=1 d=%h pe=%b fe=%b",
                         exp_q[i].dut, exp_q[i].cyc, vlog[exp_q[i].dut][exp_q[i].cyc],
                         dlog[exp_q[i].dut][exp_q[i].cyc], pelog[exp_q[i].dut][exp_q[i].cyc],
                         felog[exp_q[i].dut][exp_q[i].cyc], exp_q[i].data, exp_q[i].pe, exp_q[i].fe);
            end
        end
        checks++;
        if ({blog[0][61], blog[0][63], blog[1][63]} !== 3'b100) begin
            errors++;
            $display("FAIL false_start busy: got %b%b%b, expected 100", blog[0][61], blog[0][63], blog[1][63]);
        end
        checks++;
        if (dlog[0][89] !== 16'h005A || pelog[0][89] !== 1'b1 || dlog[1][89] !== 16'h005A || pelog[1][89] !== 1'b1) begin
            errors++;
            $display("FAIL false_start flags: got d0=%h pe0=%b d1=%h pe1=%b, expected 005a 1 005a 1",
                     dlog[0][89], pelog[0][89], dlog[1][89], pelog[1][89]);
        end
    endtask

    task automatic test_back_to_back();
        int  e;
        bit  hit;
        clear_stim();
        e = add_frame(2, 0, 16'h01, 1'b0, 1'b1, 1);
        e = add_frame(2, e, 16'hFE, 1'b0, 1'b1, 1);
        e = 0;
        for (int k = 0; k < 3; k++) e = add_frame(3, e, 16'($urandom), 1'b0, 1'b1, 1);
        run(100);
        collect(100);
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL back_to_back strobe count: got %0d, expected %0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            hit = 0;
            foreach (obs[j]) if (obs[j] == exp_q[i]) hit = 1;
            checks++;
            if (!hit) begin
                errors++;
                $display("FAIL back_to_back strobe dut%0d@%0d: got v=%b d=%h pe=%b fe=%b, expected v=1 d=%h pe=%b fe=%b",
                         exp_q[i].dut, exp_q[i].cyc, vlog[exp_q[i].dut][exp_q[i].cyc],
                         dlog[exp_q[i].dut][exp_q[i].cyc], pelog[exp_q[i].dut][exp_q[i].cyc],
                         felog[exp_q[i].dut][exp_q[i].cyc], exp_q[i].data, exp_q[i].pe, exp_q[i].fe);
            end
        end
        checks++;
        if ({blog[2][39], blog[2][41]} !== 2'b01) begin
            errors++;
            $display("FAIL back_to_back busy: got %b%b at cycles 39,41, expected 01", blog[2][39], blog[2][41]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int  e;
        bit  hit;
        clear_stim();
        e = add_frame(0, 0,  16'hC3, 1'b1, 1'b0, 1);
        e = add_frame(0, 50, 16'h96, 1'b0, 1'b1, 0);
        rst_wave[70] = 1'b1;
        rst_wave[71] = 1'b1;
        for (int t = 72; t < 80; t++) wave[0][t] = 1'b1;
        e = add_frame(0, 80, 16'h55, 1'b0, 1'b1, 1);
        run(140);
        collect(140);
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL reset_mid strobe count: got %0d, expected %0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            hit = 0;
            foreach (obs[j]) if (obs[j] == exp_q[i]) hit = 1;
            checks++;
            if (!hit) begin
                errors++;
                $display("FAIL reset_mid strobe dut%0d@%0d: got v=%b d=%h pe=%b fe=%b, expected v=1 d=%h pe=%b fe=%b",
                         exp_q[i].dut, exp_q[i].cyc, vlog[exp_q[i].dut][exp_q[i].cyc],
                         dlog[exp_q[i].dut][exp_q[i].cyc], pelog[exp_q[i].dut][exp_q[i].cyc],
                         felog[exp_q[i].dut][exp_q[i].cyc], exp_q[i].data, exp_q[i].pe, exp_q[i].fe);
            end
        end
        checks++;
        if ({pelog[0][69], felog[0][69], blog[0][69]} !== 3'b111) begin
            errors++;
            $display("FAIL reset_mid before: got pe=%b fe=%b busy=%b, expected 1 1 1",
                     pelog[0][69], felog[0][69], blog[0][69]);
        end
        checks++;
        if ({vlog[0][72], dlog[0][72], pelog[0][72], felog[0][72], blog[0][72]} !== 20'h0) begin
            errors++;
            $display("FAIL reset_mid after: got v=%b d=%h pe=%b fe=%b busy=%b, expected all 0",
                     vlog[0][72], dlog[0][72], pelog[0][72], felog[0][72], blog[0][72]);
        end
    endtask

    task automatic test_random();
        int   t, len;
        bit   hit;
        logic stopb;
        for (int r = 0; r < 4; r++) begin
            clear_stim();
            for (int d = 0; d < ND; d++) begin
                len = (W_CFG[d] + 2 + ((PM_CFG[d] == 1 || PM_CFG[d] == 2) ? 1 : 0)) * C_CFG[d];
                t   = int'($urandom_range(0, 5));
                while (t + len + 8 < 380) begin
                    stopb = ($urandom_range(0, 4) != 0);
                    t = add_frame(d, t, 16'($urandom), 1'($urandom_range(0, 1)), stopb, 1);
                    t = t + int'($urandom_range(stopb ? 0 : 1, 4));
                end
            end
            run(380);
            collect(380);
            checks++;
            if (obs.size() != exp_q.size()) begin
                errors++;
                $display("FAIL random round %0d strobe count: got %0d, expected %0d", r, obs.size(), exp_q.size());
            end
            foreach (exp_q[i]) begin
                hit = 0;
                foreach (obs[j]) if (obs[j] == exp_q[i]) hit = 1;
                checks++;
                if (!hit) begin
                    errors++;
                    $display("FAIL random strobe dut%0d@%0d: got v=%b d=%h pe=%b fe=%b, expected v=1 d=%h pe=%b fe=%b",
                             exp_q[i].dut, exp_q[i].cyc, vlog[exp_q[i].dut][exp_q[i].cyc],
                             dlog[exp_q[i].dut][exp_q[i].cyc], pelog[exp_q[i].dut][exp_q[i].cyc],
                             felog[exp_q[i].dut][exp_q[i].cyc], exp_q[i].data, exp_q[i].pe, exp_q[i].fe);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        ser = '1;
        test_reset();
        test_nominal();
        test_framing();
        test_false_start();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
